// File: rtl/nes_bus_pkg.sv
// Shared CPU bus definitions for the NES-style bus stage:
// trigger/destination addresses and the OAM DMA state encoding.
package nes_bus_pkg;

    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] OAM_PORT = 16'h2004;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA bus stage: transparent in IDLE, otherwise stalls the
// core and copies one page to the PPU OAM port, 2 cycles a byte.
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter int NBYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_o_data,
    input  logic        cpu_wreq,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_o_data,
    output logic        mem_wreq,
    input  logic [7:0]  mem_i_data
);

    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    dma_state_t    state;
    logic [7:0]    page;
    logic [7:0]    latch;
    logic [IW-1:0] idx;
    logic          odd;

    logic          trig;
    logic [15:0]   src_addr;
    logic          st_idle;
    logic          st_read;
    logic          st_write;

    assign trig     = cpu_wreq && (cpu_address == DMA_REG);
    assign src_addr = {page, 8'(idx)};
    assign st_idle  = (state == IDLE);
    assign st_read  = (state == READ);
    assign st_write = (state == WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            page  <= 8'h00;
            latch <= 8'h00;
            idx   <= '0;
            odd   <= 1'b0;
        end else if (ce) begin
            odd <= ~odd;
            unique case (state)
                IDLE: begin
                    if (trig) begin
                        page  <= cpu_o_data;
                        idx   <= '0;
                        state <= HALT;
                    end
                end
                // odd now means the next cycle is even: reads start there
                HALT:  state <= odd ? READ : ALIGN;
                ALIGN: state <= READ;
                READ: begin
                    latch <= mem_i_data;
                    state <= WRITE;
                end
                WRITE: begin
                    idx   <= idx + IW'(1);
                    state <= (idx == LAST) ? IDLE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_rdy    = st_idle;
    assign dma_active = ~st_idle;

    always_comb begin
        mem_address = cpu_address;
        mem_o_data  = cpu_o_data;
        mem_wreq    = 1'b0;
        unique case (1'b1)
            st_idle: mem_wreq = cpu_wreq;
            st_read: mem_address = src_addr;
            st_write: begin
                mem_address = OAM_PORT;
                mem_o_data  = latch;
                mem_wreq    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a cycle-schedule model of each
// transfer is checked against the bus on every negedge.
module tb_oam_dma;

    typedef struct {
        logic        rdy;
        logic        act;
        logic        hold;
        logic [15:0] addr;
        logic        wreq;
        logic        dchk;
        logic [7:0]  data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_o_data;
    logic        cpu_wreq;
    logic        cpu_rdy;
    logic        dma_active;
    logic [15:0] mem_address;
    logic [7:0]  mem_o_data;
    logic        mem_wreq;
    logic [7:0]  mem_i_data;

    int checks   = 0;
    int failures = 0;
    int ce_cnt   = 0;
    int stall_cnt = 0;
    int wr_cnt   = 0;
    logic [15:0] rd_log[$];
    exp_t q[$];

    oam_dma dut (
        .clk(clk),
        .rst_n(rst_n),
        .ce(ce),
        .cpu_address(cpu_address),
        .cpu_o_data(cpu_o_data),
        .cpu_wreq(cpu_wreq),
        .cpu_rdy(cpu_rdy),
        .dma_active(dma_active),
        .mem_address(mem_address),
        .mem_o_data(mem_o_data),
        .mem_wreq(mem_wreq),
        .mem_i_data(mem_i_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input logic [15:0] a);
        return (a[7:0] * 8'd3) ^ a[15:8] ^ 8'hA5;
    endfunction

    assign mem_i_data = pat(mem_address);

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t",
                     nm, got, exp, $time);
        end
    endtask

    // One entry per stalled ce cycle: HALT, optional ALIGN, 256 read/write pairs
    task automatic push_sched(input logic [7:0] pg, input bit halt_odd);
        logic [15:0] a;
        q.push_back('{1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 8'h0});
        if (!halt_odd)
            q.push_back('{1'b0, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 8'h0});
        for (int i = 0; i < 256; i++) begin
            a = {pg, 8'(i)};
            q.push_back('{1'b0, 1'b1, 1'b0, a, 1'b0, 1'b0, 8'h0});
            q.push_back('{1'b0, 1'b1, 1'b0, 16'h2004, 1'b1, 1'b1, pat(a)});
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            q.delete();
            ce_cnt = 0;
        end else if (ce) begin
            if (q.size() > 0)
                void'(q.pop_front());
            else if (cpu_wreq && cpu_address == 16'h4014)
                push_sched(cpu_o_data, (ce_cnt % 2) == 0);
            ce_cnt++;
        end
    endtask

    task automatic cmp();
        exp_t e;
        if (!rst_n) return;
        if (q.size() > 0)
            e = q[0];
        else
            e = '{1'b1, 1'b0, 1'b1, 16'h0, cpu_wreq, 1'b1, cpu_o_data};
        chk("cpu_rdy", 32'(cpu_rdy), 32'(e.rdy));
        chk("dma_active", 32'(dma_active), 32'(e.act));
        chk("mem_address", 32'(mem_address),
            32'(e.hold ? cpu_address : e.addr));
        chk("mem_wreq", 32'(mem_wreq), 32'(e.wreq));
        if (e.dchk)
            chk("mem_o_data", 32'(mem_o_data), 32'(e.data));
        if (ce) begin
            if (!cpu_rdy) stall_cnt++;
            if (dma_active && !mem_wreq) rd_log.push_back(mem_address);
            if (dma_active && mem_wreq && mem_address == 16'h2004)
                wr_cnt++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        cpu_address = 16'hC123;
        cpu_o_data  = 8'h3C;
        cpu_wreq    = 1'b0;
    endtask

    task automatic run_dma(input logic [7:0] pg, input bit want_odd,
                           input bit gap, input int exp_len);
        int s0, w0, rb, zeros;
        bit done;
        logic [15:0] a;
        idle_bus();
        if (((ce_cnt % 2) == 0) != want_odd) cyc();
        s0 = stall_cnt;
        w0 = wr_cnt;
        rb = rd_log.size();
        cpu_address = 16'h4014;
        cpu_o_data  = pg;
        cpu_wreq    = 1'b1;
        cyc();
        // stalled core keeps presenting its write; must not be forwarded
        repeat (3) cyc();
        idle_bus();
        if (gap) begin
            repeat (40) cyc();
            a  = mem_address;
            ce = 1'b0;
            repeat (5) begin
                cyc();
                chk("ce_hold_addr", 32'(mem_address), 32'(a));
            end
            ce = 1'b1;
        end
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (cpu_rdy) done = 1'b1;
        end
        chk("dma_done", 32'(done), 32'd1);
        chk("stall_len", 32'(stall_cnt - s0), 32'(exp_len));
        chk("oam_writes", 32'(wr_cnt - w0), 32'd256);
        chk("first_read", 32'(rd_log[rb + (want_odd ? 1 : 2)]),
            32'({pg, 8'h00}));
        chk("last_read", 32'(rd_log[rd_log.size() - 1]),
            32'({pg, 8'hFF}));
        zeros = 0;
        for (int i = rb; i < rd_log.size(); i++)
            if (rd_log[i] == 16'h0000) zeros++;
        chk("no_zero_access", 32'(zeros), 32'd0);
    endtask

    initial begin
        int w0;
        bit hit;
        rst_n       = 1'b0;
        ce          = 1'b1;
        cpu_address = 16'h1234;
        cpu_o_data  = 8'h9A;
        cpu_wreq    = 1'b1;
        fork
            forever begin
                @(negedge clk);
                cmp();
            end
            forever begin
                @(posedge clk or negedge rst_n);
                model_step();
            end
        join_none

        #2;
        chk("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
        chk("rst_dma_active", 32'(dma_active), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'h1234);
        chk("rst_mem_wreq", 32'(mem_wreq), 32'd1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle_bus();

        // plain write passes straight through
        cyc();
        cpu_address = 16'h0300;
        cpu_o_data  = 8'h55;
        cpu_wreq    = 1'b1;
        @(negedge clk);
        #1;
        chk("pt_address", 32'(mem_address), 32'h0300);
        chk("pt_data", 32'(mem_o_data), 32'h55);
        chk("pt_wreq", 32'(mem_wreq), 32'd1);
        chk("pt_rdy", 32'(cpu_rdy), 32'd1);
        cyc();

        run_dma(8'h02, 1'b1, 1'b0, 513);
        run_dma(8'h02, 1'b0, 1'b0, 514);
        run_dma(8'h05, 1'b0, 1'b1, 514);

        // reset in the middle of a transfer
        idle_bus();
        cyc();
        w0 = wr_cnt;
        cpu_address = 16'h4014;
        cpu_o_data  = 8'h03;
        cpu_wreq    = 1'b1;
        cyc();
        idle_bus();
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (wr_cnt - w0 >= 128) hit = 1'b1;
        end
        chk("mid_reached", 32'(hit), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(cpu_rdy), 32'd1);
        chk("mid_rst_active", 32'(dma_active), 32'd0);
        chk("mid_rst_addr", 32'(mem_address), 32'hC123);
        chk("mid_rst_writes", 32'(wr_cnt - w0), 32'd128);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        cyc();
        cpu_address = 16'h0301;
        cpu_o_data  = 8'h77;
        cpu_wreq    = 1'b1;
        @(negedge clk);
        #1;
        chk("post_rst_addr", 32'(mem_address), 32'h0301);
        chk("post_rst_data", 32'(mem_o_data), 32'h77);
        chk("post_rst_wreq", 32'(mem_wreq), 32'd1);
        cyc();

        run_dma(8'hFF, 1'b1, 1'b0, 513);
        run_dma(8'h20, 1'b1, 1'b0, 513);
        idle_bus();
        repeat (4) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
